vga_timing_ctrl: RTL and testbench
==================================

# vga_timing_ctrl

Raster sequencer for the VGA output path. It consumes the 25 MHz pixel strobe produced from the 100 MHz system clock and steps horizontal and vertical position counters through active, front-porch, sync and back-porch phases. It produces registered sync, data-enable and pixel-coordinate outputs, plus one-clock line and frame markers, for the pixel generator and the display pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- pix_stb  in  1  pixel-advance enable, one clk wide
- hs_n  out  1  horizontal sync, active low
- vs_n  out  1  vertical sync, active low
- de  out  1  data enable, high only inside the active area
- x  out  10  horizontal position, 0..H_TOTAL-1
- y  out  10  vertical position, 0..V_TOTAL-1
- line_start  out  1  one-clk pulse when outputs take x=0
- frame_start  out  1  one-clk pulse when outputs take x=0, y=0

## Operation
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- h_cnt and v_cnt are 10-bit internal counters. They advance only on clk edges where pix_stb=1.
- Horizontal counter:
  - h_cnt wraps from H_TOTAL-1 to 0.
  - v_cnt increments only on the strobe where h_cnt wraps.
- Vertical counter: v_cnt wraps from V_TOTAL-1 to 0.
- Per-axis phase FSM with states ACTIVE, FRONT, SYNC, BACK:
  - ACTIVE→FRONT when the count reaches ACTIVE.
  - FRONT→SYNC when it reaches ACTIVE+FP.
  - SYNC→BACK when it reaches ACTIVE+FP+SYNC.
  - BACK→ACTIVE on wrap.
  - The vertical FSM transitions only on a line wrap.
- Registered outputs, updated on strobe edges from the pre-increment counter and phase values:
  - x=h_cnt, y=v_cnt.
  - hs_n = !(h phase==SYNC).
  - vs_n = !(v phase==SYNC).
  - de = (h phase==ACTIVE) && (v phase==ACTIVE).
- Pulses:
  - line_start=1 on the strobe edge that loads x=0, otherwise 0.
  - frame_start additionally requires y=0.
  - Both pulses clear on the next clk regardless of pix_stb.
- pix_stb held low: all outputs hold, and the pulses clear after one clk.
- pix_stb high every clk: the raster runs at clk rate with identical sequencing.

## Timing
- Reset (async assert, sync-safe release):
  - h_cnt=0, v_cnt=0, both FSMs in ACTIVE.
  - hs_n=1, vs_n=1, de=0, x=0, y=0, line_start=0, frame_start=0.
- First strobe after reset: outputs show (0,0) with de=1, line_start=1 and frame_start=1. Counters move to (1,0).
- Latency: outputs lag the internal counters by exactly one strobe. There is no clk-based latency beyond the registering edge.
- Default sync positions:
  - hs_n=0 for x in 656..751.
  - vs_n=0 for y in 490..491, across the full line width.
- Reset mid-frame: all state returns to reset values immediately. The next strobe starts a fresh frame.

## Configuration
- VGA_FRAME_CNT_EN:
  - Defined: adds output frame_cnt [15:0], reset 0, incremented on the clk edge that asserts frame_start, wrapping from 0xFFFF to 0.
  - Undefined: the port and counter are absent, and all other behaviour is identical.

## Structure
- Package vga_pkg holds the default timing constants (all eight, plus H_TOTAL/V_TOTAL), the 2-bit phase typedef {ACTIVE, FRONT, SYNC, BACK}, and the coordinate width constant (10).
- Sub-module vga_axis_counter contains the counter plus phase FSM for one axis, with parameters ACTIVE/FP/SYNC/BP and ports clk, rst, en, cnt, phase, wrap. It is instantiated twice:
  - horizontal: en=pix_stb
  - vertical: en=pix_stb & h_wrap

## Test plan
- Reset behaviour: assert rst with no strobes → hs_n=1, vs_n=1, de=0, x=0, y=0, pulses 0; first strobe after release → x=0, y=0, de=1, frame_start=1 for one clk.
- Horizontal sync window: pix_stb every 4th clk for one line → hs_n=0 exactly for x 656..751, de=0 for x≥640, line_start once per 800 strobes.
- Vertical sync window: run one full frame → vs_n=0 exactly for y 490..491, de=0 for y≥480, y wraps 524→0.
- Frame period: count strobes between frame_start pulses → 420000 strobes; with pix_stb=1 every clk → 420000 clks.
- Reset mid-line: assert rst at x=300, y=100 → outputs return to reset values immediately; next strobe gives x=0, y=0, frame_start=1.
- With VGA_FRAME_CNT_EN: preload the count via 65535 frames or force it → frame_cnt goes 0xFFFF→0 on the next frame_start.

Source files
------------

// File: rtl/vga_pkg.sv
// Default VGA 640x480@60 timing constants, coordinate width and the per-axis phase type.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int COORD_W  = 10;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Raster output bundle between the timing controller and the pixel path.
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_ctrl_if;
  import vga_pkg::*;

  logic               pix_stb;
  logic               hs_n;
  logic               vs_n;
  logic               de;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               line_start;
  logic               frame_start;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0]        frame_cnt;
`endif

  modport master (
    input  pix_stb,
    output hs_n, vs_n, de, x, y, line_start, frame_start
`ifdef VGA_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output pix_stb,
    input  hs_n, vs_n, de, x, y, line_start, frame_start
`ifdef VGA_FRAME_CNT_EN
    , input frame_cnt
`endif
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase tracker.
// phase always describes the current cnt value; wrap flags the enabled last count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE,
  parameter int FP     = H_FP,
  parameter int SYNC   = H_SYNC,
  parameter int BP     = H_BP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [COORD_W-1:0] cnt,
  output phase_t             phase,
  output logic               wrap
);

  localparam logic [COORD_W-1:0] A_END = COORD_W'(ACTIVE);
  localparam logic [COORD_W-1:0] F_END = COORD_W'(ACTIVE + FP);
  localparam logic [COORD_W-1:0] S_END = COORD_W'(ACTIVE + FP + SYNC);
  localparam logic [COORD_W-1:0] LAST  = COORD_W'(ACTIVE + FP + SYNC + BP - 1);

  logic               at_last;
  logic [COORD_W-1:0] nxt;

  assign at_last = (cnt == LAST);
  assign wrap    = en && at_last;
  assign nxt     = at_last ? '0 : cnt + 1'b1;

  // Phase changes are decided from the count being entered, so phase and cnt stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= PH_ACTIVE;
    end else if (en) begin
      cnt <= nxt;
      case (phase)
        PH_ACTIVE: if (nxt == A_END) phase <= PH_FRONT;
        PH_FRONT:  if (nxt == F_END) phase <= PH_SYNC;
        PH_SYNC:   if (nxt == S_END) phase <= PH_BACK;
        PH_BACK:   if (at_last)      phase <= PH_ACTIVE;
        default:                     phase <= PH_ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: two axis counters plus one registered output stage.
// Optional feature macro: VGA_FRAME_CNT_EN adds a 16-bit wrapping frame counter.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACT = H_ACTIVE,
  parameter int H_F   = H_FP,
  parameter int H_S   = H_SYNC,
  parameter int H_B   = H_BP,
  parameter int V_ACT = V_ACTIVE,
  parameter int V_F   = V_FP,
  parameter int V_S   = V_SYNC,
  parameter int V_B   = V_BP
) (
  input  logic                clk,
  input  logic                rst,
  vga_timing_ctrl_if.master   bus
);

  logic [COORD_W-1:0] h_cnt, v_cnt;
  phase_t             h_ph, v_ph;
  logic               h_wrap;
  logic               v_wrap_unused;

  vga_axis_counter #(.ACTIVE(H_ACT), .FP(H_F), .SYNC(H_S), .BP(H_B)) u_h (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.pix_stb),
    .cnt   (h_cnt),
    .phase (h_ph),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(.ACTIVE(V_ACT), .FP(V_F), .SYNC(V_S), .BP(V_B)) u_v (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.pix_stb & h_wrap),
    .cnt   (v_cnt),
    .phase (v_ph),
    .wrap  (v_wrap_unused)
  );

  logic               hs_n_p1, vs_n_p1, de_p1, line_start_p1, frame_start_p1;
  logic [COORD_W-1:0] x_p1, y_p1;
  logic               at_origin;

  assign at_origin = (h_cnt == '0) && (v_cnt == '0);

  // Stage p1: outputs capture the pre-increment counters; pulses self-clear every clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_n_p1        <= 1'b1;
      vs_n_p1        <= 1'b1;
      de_p1          <= 1'b0;
      x_p1           <= '0;
      y_p1           <= '0;
      line_start_p1  <= 1'b0;
      frame_start_p1 <= 1'b0;
    end else begin
      line_start_p1  <= 1'b0;
      frame_start_p1 <= 1'b0;
      if (bus.pix_stb) begin
        x_p1           <= h_cnt;
        y_p1           <= v_cnt;
        hs_n_p1        <= (h_ph != PH_SYNC);
        vs_n_p1        <= (v_ph != PH_SYNC);
        de_p1          <= (h_ph == PH_ACTIVE) && (v_ph == PH_ACTIVE);
        line_start_p1  <= (h_cnt == '0);
        frame_start_p1 <= at_origin;
      end
    end
  end

  assign bus.hs_n        = hs_n_p1;
  assign bus.vs_n        = vs_n_p1;
  assign bus.de          = de_p1;
  assign bus.x           = x_p1;
  assign bus.y           = y_p1;
  assign bus.line_start  = line_start_p1;
  assign bus.frame_start = frame_start_p1;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_p1 <= '0;
    end else if (bus.pix_stb && at_origin) begin
      frame_cnt_p1 <= frame_cnt_p1 + 16'd1;
    end
  end

  assign bus.frame_cnt = frame_cnt_p1;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized bench for vga_timing_ctrl: a default-timing instance and a shrunken-timing
// instance run side by side against an arithmetic raster model (position from strobe count).
module tb_vga_timing_ctrl;

  localparam int SHA = 16, SHF = 4, SHS = 6, SHB = 4;
  localparam int SVA = 10, SVF = 3, SVS = 2, SVB = 5;
  localparam int S_FRAME = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stb = 1'b0;

  always #5 clk = ~clk;

  vga_timing_ctrl_if bus_d ();
  vga_timing_ctrl_if bus_s ();

  assign bus_d.pix_stb = stb;
  assign bus_s.pix_stb = stb;

  vga_timing_ctrl dut_d (
    .clk (clk),
    .rst (rst),
    .bus (bus_d)
  );

  vga_timing_ctrl #(
    .H_ACT(SHA), .H_F(SHF), .H_S(SHS), .H_B(SHB),
    .V_ACT(SVA), .V_F(SVF), .V_S(SVS), .V_B(SVB)
  ) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  longint      n_d = 0, n_s = 0;
  bit          stb_last = 0;
  bit          mode_full = 0;
  longint      cyc = 0;
  longint      last_fs_s = -1, last_ls_d = -1;
  logic [15:0] fc_d, fc_s;

`ifdef VGA_FRAME_CNT_EN
  assign fc_d = bus_d.frame_cnt;
  assign fc_s = bus_s.frame_cnt;
`else
  assign fc_d = 16'd0;
  assign fc_s = 16'd0;
`endif

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs after n accepted strobes: position n-1 in raster order.
  task automatic check_dut(input string tag,
                           input int ha, input int hf, input int hs, input int hb,
                           input int va, input int vf, input int vs, input int vb,
                           input longint n, input bit pulse,
                           input logic o_hs_n, input logic o_vs_n, input logic o_de,
                           input logic [9:0] o_x, input logic [9:0] o_y,
                           input logic o_ls, input logic o_fs, input logic [15:0] o_fc);
    longint htot, tot, p, ex, ey, efc;
    bit ehs, evs, ede, els, efs;
    htot = ha + hf + hs + hb;
    tot  = htot * (va + vf + vs + vb);
    if (n == 0) begin
      ex = 0; ey = 0; ehs = 1; evs = 1; ede = 0; els = 0; efs = 0; efc = 0;
    end else begin
      p   = (n - 1) % tot;
      ex  = p % htot;
      ey  = p / htot;
      ehs = !(ex >= ha + hf && ex < ha + hf + hs);
      evs = !(ey >= va + vf && ey < va + vf + vs);
      ede = (ex < ha) && (ey < va);
      els = pulse && (ex == 0);
      efs = els && (ey == 0);
      efc = ((n - 1) / tot + 1) % 65536;
    end
    check_val({tag, ".x"},           o_x,    ex);
    check_val({tag, ".y"},           o_y,    ey);
    check_val({tag, ".hs_n"},        o_hs_n, ehs);
    check_val({tag, ".vs_n"},        o_vs_n, evs);
    check_val({tag, ".de"},          o_de,   ede);
    check_val({tag, ".line_start"},  o_ls,   els);
    check_val({tag, ".frame_start"}, o_fs,   efs);
`ifdef VGA_FRAME_CNT_EN
    check_val({tag, ".frame_cnt"},   o_fc,   efc);
`else
    if (o_fc !== 16'd0) check_val({tag, ".fc_tie"}, o_fc, 0);
`endif
  endtask

  task automatic check_both(input string tag);
    check_dut({tag, "_d"}, vga_pkg::H_ACTIVE, vga_pkg::H_FP, vga_pkg::H_SYNC, vga_pkg::H_BP,
              vga_pkg::V_ACTIVE, vga_pkg::V_FP, vga_pkg::V_SYNC, vga_pkg::V_BP,
              n_d, stb_last, bus_d.hs_n, bus_d.vs_n, bus_d.de, bus_d.x, bus_d.y,
              bus_d.line_start, bus_d.frame_start, fc_d);
    check_dut({tag, "_s"}, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB,
              n_s, stb_last, bus_s.hs_n, bus_s.vs_n, bus_s.de, bus_s.x, bus_s.y,
              bus_s.line_start, bus_s.frame_start, fc_s);
  endtask

  // Present s for one clk edge, then advance the model and check #1 after the edge.
  task automatic cycle(input bit s, input string tag);
    bit applied;
    stb = s;
    @(posedge clk);
    #1;
    cyc++;
    applied  = s && !rst;
    stb_last = applied;
    if (applied) begin
      n_d++;
      n_s++;
    end
    check_both(tag);
    if (mode_full && bus_s.frame_start) begin
      if (last_fs_s >= 0) check_val("frame_period_s", cyc - last_fs_s, S_FRAME);
      last_fs_s = cyc;
    end
    if (mode_full && bus_d.line_start) begin
      if (last_ls_d >= 0) check_val("line_period_d", cyc - last_ls_d, vga_pkg::H_TOTAL);
      last_ls_d = cyc;
    end
  endtask

  task automatic async_reset(input string tag);
    stb = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_d = 0;
    n_s = 0;
    stb_last = 0;
    check_both({tag, "_imm"});
    cycle(1'b1, {tag, "_held"});
    cycle(1'b0, {tag, "_held"});
    rst = 1'b0;
  endtask

  initial begin
    bit found;
    // Reset held, strobes ignored.
    for (int i = 0; i < 4; i++) cycle(i[0], "rst");
    rst = 1'b0;
    cycle(1'b0, "idle");
    cycle(1'b1, "first");
    cycle(1'b0, "first_clr");

    // Strobe every 4th clk across more than one default line.
    for (int i = 0; i < 810 * 4; i++) cycle(i % 4 == 3, "every4");

    // Random strobe density.
    for (int i = 0; i < 1500; i++) cycle($urandom_range(0, 2) != 0, "rand");

    // Reset in the middle of a default line at x=300.
    found = 0;
    for (int i = 0; i < 4000 && !found; i++) begin
      cycle($urandom_range(0, 1) != 0, "seek");
      if (bus_d.x == 10'd300) found = 1;
    end
    check_val("seek_x300_found", found, 1);
    async_reset("midline");
    cycle(1'b1, "restart");
    cycle(1'b0, "restart_clr");

    // Random reset point on the small raster.
    for (int i = 0; i < $urandom_range(50, 400); i++) cycle($urandom_range(0, 3) != 0, "rand2");
    async_reset("midframe");

    // Strobe every clk: clk-rate raster with measured line/frame periods.
    mode_full = 1;
    for (int i = 0; i < 1700; i++) cycle(1'b1, "full");
    mode_full = 0;
    check_val("frame_period_seen", (last_fs_s >= 0), 1);
    for (int i = 0; i < 3; i++) cycle(1'b0, "hold");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
